spike_history_ring: RTL and testbench

//  Parametrised episode recorder for the layer1/2/3 spike vectors (input, hippo, output).

---
 rtl/spike_history_ring_pkg.sv | 14 +
 rtl/spike_history_ring_mem.sv | 28 ++
 rtl/spike_history_ring.sv | 150 +++++++++++++++
 tb/tb_spike_history_ring.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/spike_history_ring_pkg.sv
// Shared widths, depth default and FSM encoding for the spike episode recorder.
// Layer widths mirror the network parameter set; HIST_DEPTH sets the history length.
package spike_history_ring_pkg;

  localparam int Neurons_Layer1 = 8;
  localparam int Neurons_Layer2 = 6;
  localparam int Neurons_Layer3 = 4;
  localparam int HIST_DEPTH     = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

endpackage

// File: rtl/spike_history_ring_mem.sv
// History storage: DEPTH x W register array, one write port,
// one registered read port, storage deliberately left unreset.
module hist_ring_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 18,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_q;

  // Read-before-write: a same-cycle overwrite returns the old entry
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/spike_history_ring.sv
// Episode recorder: per-step snapshots of input/hippo/output spike vectors
// in a circular history, frozen at episode end and read back by age.
module spike_history_ring
  import spike_history_ring_pkg::*;
#(
  parameter int IN_W   = Neurons_Layer1,
  parameter int HID_W  = Neurons_Layer2,
  parameter int OUT_W  = Neurons_Layer3,
  parameter int DEPTH  = HIST_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int ACC_OR = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ep_start,
  input  logic             ep_end,
  input  logic             step_commit,
  input  logic [IN_W-1:0]  in_vec,
  input  logic [HID_W-1:0] hid_vec,
  input  logic [OUT_W-1:0] out_vec,
  input  logic             rd_req,
  input  logic [PTR_W-1:0] rd_age,
  output logic             rd_valid,
  output logic             rd_miss,
  output logic [IN_W-1:0]  rd_in,
  output logic [HID_W-1:0] rd_hid,
  output logic [OUT_W-1:0] rd_out,
  output logic [PTR_W:0]   count,
  output logic             recording,
  output logic             frozen
);

  localparam int EW = IN_W + HID_W + OUT_W;
  localparam logic [PTR_W-1:0] LP_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] LP_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   LP_DEPTH = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   LP_CONE  = (PTR_W + 1)'(1);

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [HID_W-1:0] r_acc_hid;
  logic [OUT_W-1:0] r_acc_out;
  logic             r_rd_valid;
  logic             r_rd_miss;
  logic             r_rd_zero;

  logic             w_rec;
  logic             w_commit;
  logic             w_we;
  logic             w_miss;
  logic [HID_W-1:0] w_hid_next;
  logic [OUT_W-1:0] w_out_next;
  logic [PTR_W-1:0] w_ptr_next;
  logic [PTR_W:0]   w_cnt_next;
  logic [PTR_W-1:0] w_raddr;
  logic [PTR_W-1:0] w_age_addr;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_rdata;

  assign w_rec    = (r_state == ST_RECORD);
  assign w_commit = w_rec & (step_commit | ep_end) & ~ep_start;
  assign w_we     = w_commit & ~reset;

  always_comb begin
    w_hid_next = r_acc_hid;
    w_out_next = r_acc_out;
    if (ACC_OR != 0) begin
      w_hid_next = r_acc_hid | hid_vec;
      w_out_next = r_acc_out | out_vec;
    end else begin
      if (hid_vec != '0) w_hid_next = hid_vec;
      if (out_vec != '0) w_out_next = out_vec;
    end
  end

  assign w_ptr_next = (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + LP_ONE;
  assign w_cnt_next = (r_count == LP_DEPTH) ? r_count : r_count + LP_CONE;
  assign w_wdata    = {in_vec, w_hid_next, w_out_next};

  // Age to slot: (wr_ptr - 1 - age) mod DEPTH without a modulo operator
  assign w_miss = ({1'b0, rd_age} >= r_count);

  always_comb begin
    w_age_addr = '0;
    if (r_wr_ptr > rd_age)
      w_age_addr = r_wr_ptr - rd_age - LP_ONE;
    else
      w_age_addr = LP_LAST - (rd_age - r_wr_ptr);
  end

  assign w_raddr = w_miss ? '0 : w_age_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_acc_hid  <= '0;
      r_acc_out  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_miss  <= 1'b0;
      r_rd_zero  <= 1'b1;
    end else begin
      r_rd_valid <= rd_req;
      r_rd_miss  <= rd_req & w_miss;
      if (rd_req) r_rd_zero <= w_miss;
      if (ep_start) begin
        r_state   <= ST_RECORD;
        r_wr_ptr  <= '0;
        r_count   <= '0;
        r_acc_hid <= '0;
        r_acc_out <= '0;
      end else if (w_commit) begin
        r_wr_ptr  <= w_ptr_next;
        r_count   <= w_cnt_next;
        r_acc_hid <= '0;
        r_acc_out <= '0;
        if (ep_end) r_state <= ST_FROZEN;
      end else if (w_rec) begin
        r_acc_hid <= w_hid_next;
        r_acc_out <= w_out_next;
      end
    end
  end

  hist_ring_mem #(
    .DEPTH (DEPTH),
    .W     (EW),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (rd_req),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign rd_valid  = r_rd_valid;
  assign rd_miss   = r_rd_miss;
  assign rd_in     = r_rd_zero ? '0 : w_rdata[EW-1 -: IN_W];
  assign rd_hid    = r_rd_zero ? '0 : w_rdata[OUT_W +: HID_W];
  assign rd_out    = r_rd_zero ? '0 : w_rdata[OUT_W-1:0];
  assign count     = r_count;
  assign recording = (r_state == ST_RECORD);
  assign frozen    = (r_state == ST_FROZEN);

endmodule

// File: tb/tb_spike_history_ring.sv
// Bench for spike_history_ring: two instances (DEPTH=4/OR, DEPTH=3/last-wins)
// on shared stimulus, each compared with an age-ordered history model.
module tb_spike_history_ring;

  localparam int IW = 8;
  localparam int HW = 6;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          reset, ep_start, ep_end, step_commit;
  logic [IW-1:0] in_vec;
  logic [HW-1:0] hid_vec;
  logic [OW-1:0] out_vec;
  logic          rd_req;
  logic [1:0]    rd_age;

  logic          v   [2];
  logic          ms  [2];
  logic [IW-1:0] ri  [2];
  logic [HW-1:0] rh  [2];
  logic [OW-1:0] ro  [2];
  logic [2:0]    cn  [2];
  logic          rec [2];
  logic          frz [2];

  int n_checks = 0;
  int n_err    = 0;

  int dep   [2] = '{4, 3};
  int accor [2] = '{1, 0};
  int st    [2];
  int cnt   [2];
  logic [HW-1:0]       ah   [2];
  logic [OW-1:0]       ao   [2];
  logic [IW+HW+OW-1:0] hist [2][4];
  logic                ev   [2];
  logic                em   [2];
  logic [IW-1:0]       ei   [2];
  logic [HW-1:0]       eh   [2];
  logic [OW-1:0]       eo   [2];

  always #5 clk = ~clk;

  spike_history_ring #(
    .IN_W(IW), .HID_W(HW), .OUT_W(OW), .DEPTH(4), .ACC_OR(1)
  ) u_a (
    .clk(clk), .reset(reset), .ep_start(ep_start), .ep_end(ep_end),
    .step_commit(step_commit), .in_vec(in_vec), .hid_vec(hid_vec),
    .out_vec(out_vec), .rd_req(rd_req), .rd_age(rd_age),
    .rd_valid(v[0]), .rd_miss(ms[0]), .rd_in(ri[0]), .rd_hid(rh[0]),
    .rd_out(ro[0]), .count(cn[0]), .recording(rec[0]), .frozen(frz[0])
  );

  spike_history_ring #(
    .IN_W(IW), .HID_W(HW), .OUT_W(OW), .DEPTH(3), .ACC_OR(0)
  ) u_b (
    .clk(clk), .reset(reset), .ep_start(ep_start), .ep_end(ep_end),
    .step_commit(step_commit), .in_vec(in_vec), .hid_vec(hid_vec),
    .out_vec(out_vec), .rd_req(rd_req), .rd_age(rd_age),
    .rd_valid(v[1]), .rd_miss(ms[1]), .rd_in(ri[1]), .rd_hid(rh[1]),
    .rd_out(ro[1]), .count(cn[1]), .recording(rec[1]), .frozen(frz[1])
  );

  task automatic chk(input string tag, input int m,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, m, obs, exp);
    end
  endtask

  // hist[m][k] is the entry of age k; newest is pushed at index 0
  task automatic model();
    for (int m = 0; m < 2; m++) begin
      logic [HW-1:0] nh;
      logic [OW-1:0] no;
      if (reset) begin
        st[m] = 0; cnt[m] = 0; ah[m] = '0; ao[m] = '0;
        ev[m] = 0; em[m] = 0; ei[m] = '0; eh[m] = '0; eo[m] = '0;
      end else begin
        ev[m] = rd_req;
        em[m] = 0;
        if (rd_req) begin
          if (int'(rd_age) >= cnt[m]) begin
            em[m] = 1; ei[m] = '0; eh[m] = '0; eo[m] = '0;
          end else begin
            {ei[m], eh[m], eo[m]} = hist[m][rd_age];
          end
        end
        if (ep_start) begin
          st[m] = 1; cnt[m] = 0; ah[m] = '0; ao[m] = '0;
        end else if (st[m] == 1) begin
          if (accor[m] != 0) begin
            nh = ah[m] | hid_vec;
            no = ao[m] | out_vec;
          end else begin
            nh = (hid_vec != 0) ? hid_vec : ah[m];
            no = (out_vec != 0) ? out_vec : ao[m];
          end
          if (step_commit || ep_end) begin
            for (int k = 3; k > 0; k--) hist[m][k] = hist[m][k-1];
            hist[m][0] = {in_vec, nh, no};
            cnt[m] = (cnt[m] + 1 > dep[m]) ? dep[m] : cnt[m] + 1;
            ah[m] = '0; ao[m] = '0;
            if (ep_end) st[m] = 2;
          end else begin
            ah[m] = nh; ao[m] = no;
          end
        end
      end
    end
  endtask

  task automatic tick();
    model();
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rd_valid", m, 32'(v[m]), 32'(ev[m]));
      chk("rd_miss", m, 32'(ms[m]), 32'(em[m]));
      chk("rd_in", m, 32'(ri[m]), 32'(ei[m]));
      chk("rd_hid", m, 32'(rh[m]), 32'(eh[m]));
      chk("rd_out", m, 32'(ro[m]), 32'(eo[m]));
      chk("count", m, 32'(cn[m]), 32'(cnt[m]));
      chk("recording", m, 32'(rec[m]), 32'(st[m] == 1));
      chk("frozen", m, 32'(frz[m]), 32'(st[m] == 2));
    end
  endtask

  task automatic clr();
    reset = 0; ep_start = 0; ep_end = 0; step_commit = 0;
    in_vec = '0; hid_vec = '0; out_vec = '0; rd_req = 0; rd_age = '0;
  endtask

  task automatic rd(input int age);
    rd_req = 1; rd_age = 2'(age);
    tick();
    rd_req = 0;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      st[m] = 0; cnt[m] = 0; ah[m] = '0; ao[m] = '0;
      ev[m] = 0; em[m] = 0; ei[m] = '0; eh[m] = '0; eo[m] = '0;
      for (int k = 0; k < 4; k++) hist[m][k] = '0;
    end
    clr();
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();

    // 1: three commits, read ages 0..3
    ep_start = 1; tick(); ep_start = 0;
    for (int i = 1; i <= 3; i++) begin
      hid_vec = 6'(i * 5); tick(); hid_vec = '0;
      in_vec = 8'(i); step_commit = 1; tick();
      step_commit = 0; in_vec = '0;
    end
    chk("t1_count", 0, 32'(cn[0]), 32'd3);
    for (int a = 0; a < 4; a++) begin
      rd(a);
      if (a < 3) chk("t1_data", 0, 32'(ri[0]), 32'(3 - a));
      else chk("t1_miss", 0, 32'(ms[0]), 32'd1);
    end
    tick();

    // 2: five commits wrap the DEPTH=3 ring
    ep_start = 1; tick(); ep_start = 0;
    for (int i = 1; i <= 5; i++) begin
      in_vec = 8'(i); step_commit = 1; tick();
    end
    step_commit = 0; in_vec = '0;
    chk("t2_count", 1, 32'(cn[1]), 32'd3);
    for (int a = 0; a < 3; a++) begin
      rd(a);
      chk("t2_data", 1, 32'(ri[1]), 32'(5 - a));
    end
    tick();

    // 3: OR accumulate versus last non-zero wins
    ep_start = 1; tick(); ep_start = 0;
    out_vec = 4'b0001; tick();
    out_vec = 4'b0000; tick();
    out_vec = 4'b0100; tick();
    out_vec = 4'b0000; step_commit = 1; tick(); step_commit = 0;
    rd(0);
    chk("t3_or", 0, 32'(ro[0]), 32'h5);
    chk("t3_last", 1, 32'(ro[1]), 32'h4);

    // 4: commit and end together make one commit, then frozen
    in_vec = 8'hA5; hid_vec = 6'h21;
    step_commit = 1; ep_end = 1; tick();
    step_commit = 0; ep_end = 0;
    chk("t4_frozen", 0, 32'(frz[0]), 32'd1);
    chk("t4_count", 0, 32'(cn[0]), 32'd2);
    hid_vec = 6'h3F; out_vec = 4'hF; step_commit = 1; tick(); tick();
    clr();
    rd(0); rd(1);

    // 5: start beats end while frozen
    ep_start = 1; ep_end = 1; tick();
    ep_start = 0; ep_end = 0;
    chk("t5_rec", 0, 32'(rec[0]), 32'd1);
    rd(0);
    chk("t5_miss", 0, 32'(ms[0]), 32'd1);

    // 6: reset mid-step drops accumulators
    hid_vec = 6'h30; out_vec = 4'h8; tick(); tick();
    reset = 1; tick(); reset = 0;
    hid_vec = '0; out_vec = '0;
    chk("t6_count", 0, 32'(cn[0]), 32'd0);
    ep_start = 1; tick(); ep_start = 0;
    hid_vec = 6'h02; tick(); hid_vec = '0;
    in_vec = 8'h11; step_commit = 1; tick(); step_commit = 0;
    rd(0);
    chk("t6_hid", 0, 32'(rh[0]), 32'h02);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 99) < 1);
      ep_start    = ($urandom_range(0, 99) < 4);
      ep_end      = ($urandom_range(0, 99) < 5);
      step_commit = ($urandom_range(0, 99) < 25);
      in_vec      = 8'($urandom);
      hid_vec     = ($urandom_range(0, 99) < 30) ? 6'($urandom) : '0;
      out_vec     = ($urandom_range(0, 99) < 30) ? 4'($urandom) : '0;
      rd_req      = ($urandom_range(0, 99) < 50);
      rd_age      = 2'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
